mm_arbiter: RTL and testbench

- Two-port round-robin arbiter and sequencer in front of `mainmemory`.
- Accepts line reads and writes from two requesters, for example an L1 fill port and a writeback port.
- Enforces the memory's timing: address one cycle ahead of write data, 2-cycle read latency, no back-to-back `read`.
- Returns read data with a single-cycle ack, and serializes every access so only one transaction is outstanding.

---
 rtl/mm_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mm_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_arbiter.sv
// Two-port round-robin arbiter and sequencer in front of mainmemory; one access in flight at a time.
// Build option: define MMARB_BOUNDS_CHECK_EN to reject line addresses >= ENTRIES without touching memory.
module mm_arbiter #(
    parameter int ENTRIES    = 256,
    parameter int RD_TIMEOUT = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rq0_req,
    input  logic         rq0_we,
    input  logic [26:0]  rq0_addr,
    input  logic [31:0]  rq0_be,
    input  logic [255:0] rq0_wd,
    output logic         rq0_ack,
    output logic         rq0_rvalid,
    output logic [255:0] rq0_rd,
    output logic         rq0_err,
    input  logic         rq1_req,
    input  logic         rq1_we,
    input  logic [26:0]  rq1_addr,
    input  logic [31:0]  rq1_be,
    input  logic [255:0] rq1_wd,
    output logic         rq1_ack,
    output logic         rq1_rvalid,
    output logic [255:0] rq1_rd,
    output logic         rq1_err,
    output logic [26:0]  mm_a,
    output logic [31:0]  mm_be,
    output logic [255:0] mm_wd,
    output logic         mm_write,
    output logic         mm_read,
    input  logic [255:0] mm_rd,
    input  logic         mm_valid,
    output logic         busy
);

    localparam int CNT_W = $clog2(RD_TIMEOUT + 1);
`ifdef MMARB_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_WR_ADDR,
        S_WR_DATA,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic               gnt_q, gnt_d;
    logic               we_q, we_d;
    logic [26:0]        addr_q, addr_d;
    logic [31:0]        be_q, be_d;
    logic [255:0]       wd_q, wd_d;
    logic               err_q, err_d;
    logic               oob_q, oob_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [255:0]       rd0_q, rd0_d;
    logic [255:0]       rd1_q, rd1_d;

    logic               sel;
    logic [26:0]        sel_addr;
    logic               addr_oob;
    logic               ack_now;

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path can infer a latch.
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        be_d         = be_q;
        wd_d         = wd_q;
        err_d        = err_q;
        oob_d        = oob_q;
        cnt_d        = cnt_q;
        rd0_d        = rd0_q;
        rd1_d        = rd1_q;
        sel          = (rq0_req && rq1_req) ? ~last_grant_q : rq1_req;
        sel_addr     = sel ? rq1_addr : rq0_addr;
        addr_oob     = BOUNDS_EN && ({5'd0, sel_addr} >= 32'(ENTRIES));

        unique case (state_q)
            S_IDLE: begin
                if (rq0_req || rq1_req) begin
                    gnt_d        = sel;
                    last_grant_d = sel;
                    we_d         = sel ? rq1_we : rq0_we;
                    addr_d       = sel_addr;
                    be_d         = sel ? rq1_be : rq0_be;
                    wd_d         = sel ? rq1_wd : rq0_wd;
                    err_d        = 1'b0;
                    cnt_d        = '0;
                    if (addr_oob) begin
                        err_d   = 1'b1;
                        oob_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = (sel ? rq1_we : rq0_we) ? S_WR_ADDR : S_RD_ISSUE;
                    end
                end
            end
            S_RD_ISSUE: begin
                cnt_d   = '0;
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (mm_valid) begin
                    if (gnt_q) rd1_d = mm_rd;
                    else       rd0_d = mm_rd;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_W'(RD_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WR_ADDR: state_d = S_WR_DATA;
            S_WR_DATA: state_d = S_DONE;
            S_DONE: begin
                // An out-of-range grant spends one silent cycle here so its ack lands at G+2.
                if (oob_q) oob_d = 1'b0;
                else       state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            be_q         <= '0;
            wd_q         <= '0;
            err_q        <= 1'b0;
            oob_q        <= 1'b0;
            cnt_q        <= '0;
            rd0_q        <= '0;
            rd1_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            be_q         <= be_d;
            wd_q         <= wd_d;
            err_q        <= err_d;
            oob_q        <= oob_d;
            cnt_q        <= cnt_d;
            rd0_q        <= rd0_d;
            rd1_q        <= rd1_d;
        end
    end

    assign ack_now    = (state_q == S_DONE) && !oob_q;
    assign rq0_ack    = ack_now && !gnt_q;
    assign rq1_ack    = ack_now && gnt_q;
    assign rq0_rvalid = rq0_ack && !we_q && !err_q;
    assign rq1_rvalid = rq1_ack && !we_q && !err_q;
    assign rq0_err    = rq0_ack && err_q;
    assign rq1_err    = rq1_ack && err_q;
    assign rq0_rd     = rd0_q;
    assign rq1_rd     = rd1_q;

    assign mm_a     = addr_q;
    assign mm_be    = be_q;
    assign mm_wd    = wd_q;
    assign mm_read  = (state_q == S_RD_ISSUE);
    assign mm_write = (state_q == S_WR_DATA);
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_mm_arbiter.sv
// Directed self-checking bench for mm_arbiter: scoreboard of expected completions plus a 2-cycle memory stub.
// Follows MMARB_BOUNDS_CHECK_EN the same way the design does.
module tb_mm_arbiter;

    localparam int BUDGET = 40;
    localparam logic [255:0] PAT_A5   = {32{8'hA5}};
    localparam logic [255:0] PAT_1234 = {16{16'h1234}};
    localparam logic [255:0] PAT_C3   = {32{8'hC3}};

    typedef struct {
        logic         port;
        logic         rvalid;
        logic         err;
        logic [255:0] rd;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         rq0_req, rq0_we, rq1_req, rq1_we;
    logic [26:0]  rq0_addr, rq1_addr;
    logic [31:0]  rq0_be, rq1_be;
    logic [255:0] rq0_wd, rq1_wd;
    logic         rq0_ack, rq0_rvalid, rq0_err, rq1_ack, rq1_rvalid, rq1_err;
    logic [255:0] rq0_rd, rq1_rd;
    logic [26:0]  mm_a;
    logic [31:0]  mm_be;
    logic [255:0] mm_wd, mm_rd;
    logic         mm_write, mm_read, mm_valid, busy;

    mm_arbiter #(.ENTRIES(256), .RD_TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .rq0_req(rq0_req), .rq0_we(rq0_we), .rq0_addr(rq0_addr), .rq0_be(rq0_be), .rq0_wd(rq0_wd),
        .rq0_ack(rq0_ack), .rq0_rvalid(rq0_rvalid), .rq0_rd(rq0_rd), .rq0_err(rq0_err),
        .rq1_req(rq1_req), .rq1_we(rq1_we), .rq1_addr(rq1_addr), .rq1_be(rq1_be), .rq1_wd(rq1_wd),
        .rq1_ack(rq1_ack), .rq1_rvalid(rq1_rvalid), .rq1_rd(rq1_rd), .rq1_err(rq1_err),
        .mm_a(mm_a), .mm_be(mm_be), .mm_wd(mm_wd), .mm_write(mm_write), .mm_read(mm_read),
        .mm_rd(mm_rd), .mm_valid(mm_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory stub: write on the strobe cycle, read data valid two cycles after the read strobe.
    logic [255:0] mem [0:511];
    logic         mem_mute = 1'b0;
    logic         v1 = 1'b0, v2 = 1'b0;
    logic [255:0] d1 = '0, d2 = '0;

    always @(posedge clk) begin
        if (mm_write)
            for (int b = 0; b < 32; b++)
                if (mm_be[b]) mem[mm_a[8:0]][b*8 +: 8] <= mm_wd[b*8 +: 8];
        v1 <= mm_read && !mem_mute;
        d1 <= mem[mm_a[8:0]];
        v2 <= v1;
        d2 <= d1;
    end

    assign mm_valid = v2;
    assign mm_rd    = v2 ? d2 : 'x;

    int           vectors = 0;
    int           miscompares = 0;
    int           cyc = 0;
    exp_t         sb[$];
    logic [1:0]   ack_seen = '0;
    logic         prev_read = 1'b0;
    logic [255:0] mrd0 = '0, mrd1 = '0;

    logic         tr_read  [0:BUDGET];
    logic         tr_write [0:BUDGET];
    logic         tr_busy  [0:BUDGET];
    logic [26:0]  tr_a     [0:BUDGET];
    logic [31:0]  tr_be    [0:BUDGET];
    logic [255:0] tr_wd    [0:BUDGET];

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic watch();
        exp_t e;
        ack_seen = {rq1_ack, rq0_ack};
        check("rd_wr_exclusive", 256'(mm_read & mm_write), '0);
        check("rd_back_to_back", 256'(mm_read & prev_read), '0);
        prev_read = mm_read;
        if (rq0_ack || rq1_ack) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", 256'(ack_seen), '0);
            end else begin
                e = sb.pop_front();
                check("ack_flags",
                      256'({rq1_ack, rq1_rvalid, rq1_err, rq0_ack, rq0_rvalid, rq0_err}),
                      256'(e.port ? {1'b1, e.rvalid, e.err, 3'b000} : {3'b000, 1'b1, e.rvalid, e.err}));
                check("read_data", e.port ? rq1_rd : rq0_rd, e.rd);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        watch();
    endtask

    task automatic set_req(input int p, input logic v);
        if (p == 0) rq0_req = v;
        else        rq1_req = v;
    endtask

    // Drives one request, traces memory-side signals per cycle (index k = cycle G+k), returns ack latency.
    task automatic issue(input logic port, input logic we, input logic [26:0] addr,
                         input logic [255:0] wd, output int lat);
        lat = 0;
        if (port) begin rq1_we = we; rq1_addr = addr; rq1_be = '1; rq1_wd = wd; rq1_req = 1'b1; end
        else      begin rq0_we = we; rq0_addr = addr; rq0_be = '1; rq0_wd = wd; rq0_req = 1'b1; end
        for (int k = 1; k <= BUDGET; k++) begin
            tick();
            tr_read[k]  = mm_read;
            tr_write[k] = mm_write;
            tr_busy[k]  = busy;
            tr_a[k]     = mm_a;
            tr_be[k]    = mm_be;
            tr_wd[k]    = mm_wd;
            if (ack_seen[port]) begin
                lat = k;
                break;
            end
        end
        if (port) rq1_req = 1'b0;
        else      rq0_req = 1'b0;
        check("ack_within_budget", 256'(lat != 0), 256'(1));
    endtask

    initial begin
        int lat;
        int rem [2];
        int hold [2];

        for (int i = 0; i < 512; i++) mem[i] = '0;
        mem[5]   = PAT_A5;
        mem[256] = PAT_C3;
        rst_n = 1'b0;
        rq0_req = 1'b0; rq0_we = 1'b0; rq0_addr = '0; rq0_be = '0; rq0_wd = '0;
        rq1_req = 1'b0; rq1_we = 1'b0; rq1_addr = '0; rq1_be = '0; rq1_wd = '0;

        // Reset state
        repeat (3) tick();
        check("rst_flags", 256'({rq0_ack, rq0_rvalid, rq0_err, rq1_ack, rq1_rvalid, rq1_err,
                                 busy, mm_read, mm_write}), '0);
        check("rst_mm_a", 256'(mm_a), '0);
        check("rst_mm_be", 256'(mm_be), '0);
        check("rst_mm_wd", mm_wd, '0);
        check("rst_rq0_rd", rq0_rd, '0);
        check("rst_rq1_rd", rq1_rd, '0);
        rst_n = 1'b1;
        tick();

        // Single read on port 0
        sb.push_back('{port: 1'b0, rvalid: 1'b1, err: 1'b0, rd: PAT_A5});
        mrd0 = PAT_A5;
        issue(1'b0, 1'b0, 27'd5, '0, lat);
        check("rd0_latency", 256'(lat), 256'(4));
        check("rd0_read_pulse", 256'({tr_read[1], tr_read[2], tr_read[3], tr_read[4]}), 256'(4'b1000));
        check("rd0_mm_a", 256'(tr_a[1]), 256'(5));
        check("rd0_busy", 256'({tr_busy[1], tr_busy[2], tr_busy[3], tr_busy[4]}), 256'(4'b1111));
        tick();
        check("rd0_idle_after", 256'(busy), '0);

        // Write then read on port 1
        sb.push_back('{port: 1'b1, rvalid: 1'b0, err: 1'b0, rd: mrd1});
        issue(1'b1, 1'b1, 27'd3, PAT_1234, lat);
        check("wr1_latency", 256'(lat), 256'(3));
        check("wr1_write_pulse", 256'({tr_write[1], tr_write[2], tr_write[3]}), 256'(3'b010));
        check("wr1_mm_a", 256'({tr_a[1], tr_a[2]}), 256'({27'd3, 27'd3}));
        check("wr1_mm_wd", tr_wd[2], PAT_1234);
        check("wr1_mm_be", 256'(tr_be[2]), 256'(32'hFFFF_FFFF));
        tick();
        sb.push_back('{port: 1'b1, rvalid: 1'b1, err: 1'b0, rd: PAT_1234});
        mrd1 = PAT_1234;
        issue(1'b1, 1'b0, 27'd3, '0, lat);
        check("rd1_latency", 256'(lat), 256'(4));
        tick();

        // Contention: both ports keep requesting; grants must alternate 0,1,0,1
        rq0_we = 1'b0; rq0_addr = 27'd5; rq1_we = 1'b0; rq1_addr = 27'd3;
        for (int i = 0; i < 2; i++) begin
            sb.push_back('{port: 1'b0, rvalid: 1'b1, err: 1'b0, rd: PAT_A5});
            sb.push_back('{port: 1'b1, rvalid: 1'b1, err: 1'b0, rd: PAT_1234});
        end
        rem[0] = 2; rem[1] = 2; hold[0] = 0; hold[1] = 0;
        rq0_req = 1'b1; rq1_req = 1'b1;
        for (int k = 0; k < 4 * BUDGET && (rem[0] + rem[1]) > 0; k++) begin
            tick();
            for (int p = 0; p < 2; p++) begin
                if (ack_seen[p]) begin
                    rem[p]--;
                    hold[p] = 2;
                    set_req(p, 1'b0);
                end else if (hold[p] > 0) begin
                    hold[p]--;
                    if (hold[p] == 0 && rem[p] > 0) set_req(p, 1'b1);
                end
            end
        end
        check("contention_done", 256'(rem[0] + rem[1]), '0);
        check("contention_sb_empty", 256'(sb.size()), '0);
        repeat (2) tick();

        // Reset in the middle of a read: abandoned, no ack, stale mm_valid ignored
        rq0_we = 1'b0; rq0_addr = 27'd5; rq0_req = 1'b1;
        tick();
        check("mid_rst_read_issued", 256'(mm_read), 256'(1));
        rst_n = 1'b0;
        rq0_req = 1'b0;
        tick();
        check("mid_rst_quiet", 256'({busy, mm_read, mm_write}), '0);
        check("mid_rst_mm_a", 256'(mm_a), '0);
        check("mid_rst_rq0_rd", rq0_rd, '0);
        mrd0 = '0;
        rst_n = 1'b1;
        repeat (6) tick();
        check("mid_rst_no_ack_busy", 256'(busy), '0);
        sb.push_back('{port: 1'b0, rvalid: 1'b1, err: 1'b0, rd: PAT_A5});
        mrd0 = PAT_A5;
        issue(1'b0, 1'b0, 27'd5, '0, lat);
        check("post_rst_latency", 256'(lat), 256'(4));
        tick();

        // Read timeout: memory never answers
        mem_mute = 1'b1;
        sb.push_back('{port: 1'b0, rvalid: 1'b0, err: 1'b1, rd: mrd0});
        issue(1'b0, 1'b0, 27'd9, '0, lat);
        check("timeout_latency", 256'(lat), 256'(10));
        check("timeout_read_issued", 256'(tr_read[1]), 256'(1));
        mem_mute = 1'b0;
        repeat (3) tick();

        // Address beyond ENTRIES
`ifdef MMARB_BOUNDS_CHECK_EN
        sb.push_back('{port: 1'b1, rvalid: 1'b0, err: 1'b1, rd: mrd1});
        issue(1'b1, 1'b0, 27'd256, '0, lat);
        check("oob_latency", 256'(lat), 256'(2));
        check("oob_no_read", 256'({tr_read[1], tr_read[2]}), '0);
`else
        sb.push_back('{port: 1'b1, rvalid: 1'b1, err: 1'b0, rd: PAT_C3});
        mrd1 = PAT_C3;
        issue(1'b1, 1'b0, 27'd256, '0, lat);
        check("oob_latency", 256'(lat), 256'(4));
        check("oob_read_issued", 256'(tr_read[1]), 256'(1));
        check("oob_mm_a", 256'(tr_a[1]), 256'(256));
`endif
        repeat (3) tick();
        check("sb_drained", 256'(sb.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
